// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: default widths, halt encoding and FSM state type.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  // All-ones halt word; wide enough to be truncated to any DATA_W up to 64.
  localparam logic [63:0] HALT_INSTR = '1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic              imem_wr;
  logic [DATA_W-1:0] imem_data;

  modport master (output imem_addr, output imem_rd, output imem_wr, input imem_data);
  modport slave  (input imem_addr, input imem_rd, input imem_wr, output imem_data);

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset clears, flush inserts a bubble, load captures, otherwise hold.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [ADDR_W-1:0] pc_d,
  output logic [DATA_W-1:0] instr_q,
  output logic [ADDR_W-1:0] pc_q,
  output logic              valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, RUN/HALTED FSM and IF/ID register feeding decode.
// Optional FETCH_PERF_CNT_EN adds a 16-bit count of valid fetches on fetch_cnt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_stage_if.master     imem,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt
`endif
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              rd_q;
  logic              halted_q;
  logic              running;
  logic              fetch;
  logic              bubble;
  logic              halt_hit;

  assign imem.imem_addr = pc;
  assign imem.imem_rd   = rd_q;
  assign imem.imem_wr   = 1'b0;
  assign halted         = halted_q;

  assign running  = (state == RUN);
  assign halt_hit = (imem.imem_data == DATA_W'(HALT_INSTR));
  assign fetch    = running & ~stall & ~redirect;
  // Redirect flushes regardless of stall; a halted, unstalled stage emits bubbles.
  assign bubble   = redirect | (~running & ~stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= ADDR_W'(RESET_PC);
      state    <= RUN;
      rd_q     <= 1'b1;
      halted_q <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      state    <= RUN;
      rd_q     <= 1'b1;
      halted_q <= 1'b0;
    end else if (fetch) begin
      if (halt_hit) begin
        state    <= HALTED;
        rd_q     <= 1'b0;
        halted_q <= 1'b1;
      end else begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load    (fetch),
    .flush   (bubble),
    .instr_d (imem.imem_data),
    .pc_d    (pc),
    .instr_q (ifid_instr),
    .pc_q    (ifid_pc),
    .valid_q (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (fetch) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a per-edge behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic [31:0] ifid_instr;
  logic [4:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0]  m_pc;
  logic        m_halted;
  logic [31:0] m_instr;
  logic [4:0]  m_ipc;
  logic        m_valid;
  logic [15:0] m_cnt;

  fetch_stage_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  assign bus.imem_data = mem[bus.imem_addr];

  fetch_stage #(
    .ADDR_W   (5),
    .DATA_W   (32),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge, updating the model from the inputs held across it.
  task automatic tick();
    logic [31:0] word;
    word = mem[m_pc];
    if (rst) begin
      m_pc = 5'd0; m_halted = 1'b0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_cnt = '0;
    end else if (redirect) begin
      m_pc = redirect_pc; m_halted = 1'b0; m_valid = 1'b0;
    end else if (!stall) begin
      if (m_halted) begin
        m_valid = 1'b0;
      end else begin
        m_instr = word; m_ipc = m_pc; m_valid = 1'b1; m_cnt = m_cnt + 16'd1;
        if (word == 32'hFFFF_FFFF) m_halted = 1'b1;
        else m_pc = m_pc + 5'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem_identity();
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
  endtask

  task automatic test_reset();
    init_mem_identity();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
    checks++; if (ifid_pc !== 5'd0) begin errors++; $display("FAIL reset_ifid_pc got=%0d exp=0", ifid_pc); end
    checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", bus.imem_addr); end
    checks++; if (halted !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_wr !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got halted=%b rd=%b wr=%b exp 0/1/0", halted, bus.imem_rd, bus.imem_wr);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ifid_instr !== 32'(k) || ifid_pc !== 5'(k) || ifid_valid !== 1'b1) begin
        errors++; $display("FAIL seq_%0d got instr=%0d pc=%0d v=%b exp %0d/%0d/1", k, ifid_instr, ifid_pc, ifid_valid, k, k);
      end
    end
    checks++; if (bus.imem_addr !== 5'd6) begin errors++; $display("FAIL seq_pc got=%0d exp=6", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 5'd30; tick(); redirect = 1'b0;
    tick(); tick();
    checks++; if (ifid_pc !== 5'd31 || ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_31 got pc=%0d v=%b exp 31/1", ifid_pc, ifid_valid); end
    checks++; if (bus.imem_addr !== 5'd0) begin errors++; $display("FAIL wrap_pc got=%0d exp=0", bus.imem_addr); end
    tick();
    checks++; if (ifid_pc !== 5'd0 || ifid_valid !== 1'b1 || ifid_instr !== 32'd0) begin
      errors++; $display("FAIL wrap_0 got pc=%0d v=%b instr=%0d exp 0/1/0", ifid_pc, ifid_valid, ifid_instr);
    end
  endtask

  task automatic test_stall();
    redirect = 1'b1; redirect_pc = 5'd3; tick(); redirect = 1'b0;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.imem_addr !== 5'd4 || ifid_pc !== 5'd3 || ifid_instr !== 32'd3 || ifid_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d got pc=%0d ipc=%0d instr=%0d v=%b exp 4/3/3/1", k, bus.imem_addr, ifid_pc, ifid_instr, ifid_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (bus.imem_addr !== 5'd5 || ifid_pc !== 5'd4 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL stall_release got pc=%0d ipc=%0d v=%b exp 5/4/1", bus.imem_addr, ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 5'd20; tick();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (bus.imem_addr !== 5'd20 || ifid_valid !== 1'b0) begin
      errors++; $display("FAIL redir_stall got pc=%0d v=%b exp 20/0", bus.imem_addr, ifid_valid);
    end
    tick();
    checks++; if (ifid_pc !== 5'd20 || ifid_instr !== 32'd20 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL redir_fetch got ipc=%0d instr=%0d v=%b exp 20/20/1", ifid_pc, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_halt();
    mem[6] = 32'hFFFF_FFFF;
    redirect = 1'b1; redirect_pc = 5'd5; tick(); redirect = 1'b0;
    tick();
    tick();
    checks++; if (ifid_instr !== 32'hFFFF_FFFF || ifid_pc !== 5'd6 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL halt_latch got instr=%h ipc=%0d v=%b exp ffffffff/6/1", ifid_instr, ifid_pc, ifid_valid);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || bus.imem_rd !== 1'b0 || ifid_valid !== 1'b0 || bus.imem_addr !== 5'd6) begin
        errors++; $display("FAIL halt_state_%0d got h=%b rd=%b v=%b pc=%0d exp 1/0/0/6", k, halted, bus.imem_rd, ifid_valid, bus.imem_addr);
      end
    end
    redirect = 1'b1; redirect_pc = 5'd0; tick(); redirect = 1'b0;
    checks++; if (halted !== 1'b0 || bus.imem_rd !== 1'b1 || ifid_valid !== 1'b0) begin
      errors++; $display("FAIL halt_exit got h=%b rd=%b v=%b exp 0/1/0", halted, bus.imem_rd, ifid_valid);
    end
    tick();
    checks++; if (ifid_pc !== 5'd0 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL halt_resume got ipc=%0d v=%b exp 0/1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_reset_in_halt();
    redirect = 1'b1; redirect_pc = 5'd6; tick(); redirect = 1'b0;
    tick(); tick();
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 5'd17; tick();
    checks++; if (halted !== 1'b0 || bus.imem_addr !== 5'd0 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_pc !== 5'd0) begin
      errors++; $display("FAIL rst_halt got h=%b pc=%0d v=%b instr=%h ipc=%0d exp all 0", halted, bus.imem_addr, ifid_valid, ifid_instr, ifid_pc);
    end
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 5'd0) begin
      errors++; $display("FAIL rst_first got v=%b ipc=%0d exp 1/0", ifid_valid, ifid_pc);
    end
    mem[6] = 32'd6;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; tick(); rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (fetch_cnt !== 16'd10) begin errors++; $display("FAIL perf_cnt got=%0d exp=10", fetch_cnt); end
    stall = 1'b1; tick(); tick(); stall = 1'b0;
    checks++; if (fetch_cnt !== 16'd10) begin errors++; $display("FAIL perf_stall got=%0d exp=10", fetch_cnt); end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (fetch_cnt !== 16'd0 || bus.imem_addr !== 5'd0) begin
      errors++; $display("FAIL perf_rst got cnt=%0d pc=%0d exp 0/0", fetch_cnt, bus.imem_addr);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = 5'($urandom_range(0, 31));
      tick();
      checks++;
      if (ifid_valid !== m_valid || ifid_pc !== m_ipc || ifid_instr !== m_instr ||
          bus.imem_addr !== m_pc || halted !== m_halted || bus.imem_rd !== !m_halted || bus.imem_wr !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d got v=%b ipc=%0d instr=%h pc=%0d h=%b rd=%b wr=%b exp v=%b ipc=%0d instr=%h pc=%0d h=%b",
                 n, ifid_valid, ifid_pc, ifid_instr, bus.imem_addr, halted, bus.imem_rd, bus.imem_wr,
                 m_valid, m_ipc, m_instr, m_pc, m_halted);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt_%0d got=%0d exp=%0d", n, fetch_cnt, m_cnt); end
`endif
    end
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    m_pc = '0; m_halted = 1'b0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_cnt = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_reset_in_halt();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_W, default 5, SHALL set the instruction-memory word-address width (32 entries).
REQ-003 Parameter DATA_W, default 32, SHALL set the instruction width.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port stall, input, 1: downstream stage cannot accept; hold PC and IF/ID.
REQ-008 Port redirect, input, 1: branch/jump taken; load redirect_pc and flush.
REQ-009 Port redirect_pc, input, ADDR_W: target word address.
REQ-010 Port imem_addr, output, ADDR_W: address to instruction memory (equals PC).
REQ-011 Port imem_rd, output, 1: read enable to instruction memory.
REQ-012 Port imem_wr, output, 1: write enable to instruction memory; constant 0.
REQ-013 Port imem_data, input, DATA_W: combinational read data from instruction memory.
REQ-014 Port ifid_instr, output, DATA_W: registered instruction for decode.
REQ-015 Port ifid_pc, output, ADDR_W: address of ifid_instr.
REQ-016 Port ifid_valid, output, 1: ifid_instr is a real instruction.
REQ-017 Port halted, output, 1: fetch FSM is in HALTED.

Function
REQ-018 FSM states SHALL be RUN and HALTED; reset enters RUN.
REQ-019 imem_addr SHALL equal PC combinationally; imem_rd SHALL be 1 in RUN and 0 in HALTED.
REQ-020 RUN, no stall/redirect: on clk edge ifid_instr<=imem_data, ifid_pc<=PC, ifid_valid<=1, PC<=PC+1; fetch latency one cycle.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W (31 -> 0 at default), no flag.
REQ-022 stall=1 (no redirect): PC, ifid_instr, ifid_pc, ifid_valid, state SHALL hold.
REQ-023 redirect=1: PC<=redirect_pc, ifid_valid<=0, state<=RUN; redirect SHALL win over stall and over HALTED.
REQ-024 RUN, not stalled, imem_data == HALT_INSTR (all ones): instruction SHALL be latched with ifid_valid=1, PC SHALL NOT advance, state<=HALTED.
REQ-025 HALTED, not stalled: ifid_valid<=0 each edge, PC held; only redirect or rst leaves HALTED.
REQ-026 halted SHALL be 1 exactly while state is HALTED.

Reset
REQ-027 On rst edge: PC<=RESET_PC, ifid_instr<=0, ifid_pc<=0, ifid_valid<=0, state<=RUN; rst SHALL override stall and redirect.
REQ-028 rst asserted mid-stall or in HALTED SHALL give the same reset values; first valid instruction appears one edge after rst deasserts.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: add output fetch_cnt, 16 bits, counting edges where ifid_valid is loaded with 1; cleared by rst, wraps at 65535 -> 0.
REQ-030 Macro FETCH_PERF_CNT_EN undefined: no fetch_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package fetch_pkg SHALL hold ADDR_W/DATA_W defaults, HALT_INSTR constant, and the RUN/HALTED state type.
REQ-032 Sub-module ifid_reg SHALL implement the IF/ID pipeline register (load, hold, flush, reset); PC and FSM stay in fetch_stage.

Verification
REQ-033 Reset then run, memory holds i at word i -> ifid_instr 0,1,2,... with ifid_pc 0,1,2, ifid_valid=1 from the second edge.
REQ-034 PC at 31, no stall -> ifid_pc=31 then 0; no glitch on ifid_valid.
REQ-035 stall=1 for 3 cycles at PC=4 -> PC and ifid outputs frozen; PC=5 one edge after release.
REQ-036 redirect=1, redirect_pc=20, stall=1 same cycle -> next edge PC=20, ifid_valid=0; next edge ifid_pc=20, ifid_valid=1.
REQ-037 Word 6 = 32'hFFFF_FFFF -> ifid_instr=FFFF_FFFF valid one cycle, then halted=1, imem_rd=0, ifid_valid=0; redirect to 0 resumes fetch.
REQ-038 With FETCH_PERF_CNT_EN, 10 unstalled fetches after reset -> fetch_cnt=10; rst asserted mid-run -> fetch_cnt=0, PC=RESET_PC.
